// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types for the RV32I hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MD_BUSY,
        ST_MEM_WAIT
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// fwd_sel : forwarding-mux select for one E-stage source operand
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    // x0 is hard-wired zero, so it is never forwarded; M is younger than W.
    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (reg_write_m && (rs == rd_m)) begin
                sel = FWD_M;
            end else if (reg_write_w && (rs == rd_w)) begin
                sel = FWD_W;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
// ============================================================================
// hazard_ctrl_mc : forwarding, load-use, branch flush and multi-cycle stall FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = $clog2(MD_LAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              MulDivE,
    input  logic              PCSrcE,
    input  logic              DMemStallM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              MdBusy
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MD_LAT - 2);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    logic md_start;
    logic md_stall;
    logic lw_hazard;
    logic lw_stall;
    logic branch_flush;
    logic stall_e_int;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    // A MUL/DIV may also start on the cycle a memory wait clears, since E
    // was held behind the memory stall and has not yet been counted.
    assign md_start  = (state != ST_MD_BUSY) && MulDivE && !PCSrcE && !DMemStallM;
    assign md_stall  = !DMemStallM &&
                       (md_start || ((state == ST_MD_BUSY) && (cnt != '0)));
    assign lw_hazard = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign lw_stall  = lw_hazard && !DMemStallM && !md_stall && !PCSrcE;

    assign stall_e_int  = DMemStallM || md_stall;
    assign branch_flush = PCSrcE && !stall_e_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_MEM_WAIT: begin
                    if (DMemStallM) begin
                        state <= ST_MEM_WAIT;
                    end else if (md_start) begin
                        state <= ST_MD_BUSY;
                        cnt   <= C_CNT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MD_BUSY: begin
                    // Counter saturates at zero while memory holds M.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!DMemStallM) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Reset forces every stage to a bubble with no holds.
    always_comb begin
        ForwardAE = rst ? FWD_RF : fwd_a;
        ForwardBE = rst ? FWD_RF : fwd_b;
        StallF    = !rst && (stall_e_int || lw_stall);
        StallD    = !rst && (stall_e_int || lw_stall);
        StallE    = !rst && stall_e_int;
        StallM    = !rst && DMemStallM;
        FlushD    = rst || branch_flush;
        FlushE    = rst || branch_flush || lw_stall;
        FlushM    = rst || md_stall;
        FlushW    = rst || DMemStallM;
        MdBusy    = !rst && (state == ST_MD_BUSY);
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
// ============================================================================
// tb_hazard_ctrl_mc : scoreboard bench for hazard_ctrl_mc
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_mc;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE, MulDivE, PCSrcE, DMemStallM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW, MdBusy;

    int n_cmp;
    int n_err;

    // {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdBusy}
    logic [12:0] sb[$];
    logic [12:0] exp_v;
    logic [12:0] obs;

    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushM, FlushW, MdBusy};

    localparam logic [12:0] V_IDLE  = 13'b00_00_0000_0000_0;
    localparam logic [12:0] V_RST   = 13'b00_00_0000_1111_0;
    localparam logic [12:0] V_MD1   = 13'b00_00_1110_0010_0;
    localparam logic [12:0] V_MDB   = 13'b00_00_1110_0010_1;
    localparam logic [12:0] V_MDEND = 13'b00_00_0000_0000_1;
    localparam logic [12:0] V_MEMB  = 13'b00_00_1111_0001_1;
    localparam logic [12:0] V_MEM   = 13'b00_00_1111_0001_0;
    localparam logic [12:0] V_LW    = 13'b00_00_1100_0100_0;
    localparam logic [12:0] V_BR    = 13'b00_00_0000_1100_0;

    hazard_ctrl_mc #(.REG_AW(5), .MD_LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .MulDivE    (MulDivE),
        .PCSrcE     (PCSrcE),
        .DMemStallM (DMemStallM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .MdBusy     (MdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE  = '0; RdM  = '0; RdW  = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 1'b0;
        MulDivE = 1'b0; PCSrcE = 1'b0; DMemStallM = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_in();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; PCSrcE = 1'b1; MulDivE = 1'b1;
        sb.push_back(V_RST);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp_v);
        end
        next_cycle();
        rst = 1'b0;
        clr_in();
        sb.push_back(V_IDLE);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        logic [4:0] ta[3]  = '{5'd5, 5'd3, 5'd0};
        logic [4:0] tb[3]  = '{5'd0, 5'd9, 5'd6};
        logic [4:0] tm[3]  = '{5'd5, 5'd3, 5'd6};
        logic [4:0] tw[3]  = '{5'd5, 5'd3, 5'd6};
        logic       twm[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0] ea[3]  = '{2'b10, 2'b01, 2'b00};
        logic [1:0] eb[3]  = '{2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            clr_in();
            Rs1E = ta[i]; Rs2E = tb[i]; RdM = tm[i]; RdW = tw[i];
            RegWriteM = twm[i]; RegWriteW = 1'b1;
            if (i == 0) RdW = 5'd5;
            sb.push_back({ea[i], eb[i], 9'b0});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL forward_%0d got=%b exp=%b", i, obs, exp_v);
            end
            next_cycle();
        end
        // W write to x0 must never forward
        clr_in();
        Rs2E = 5'd0; RdW = 5'd0; RegWriteW = 1'b1; Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1;
        sb.push_back(V_IDLE);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL forward_x0 got=%b exp=%b", obs, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            clr_in();
            case (i)
                0: begin ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; sb.push_back(V_LW); end
                1: sb.push_back(V_IDLE);
                2: begin ResultSrcE = 1'b1; RdE = 5'd0; Rs2D = 5'd0; sb.push_back(V_IDLE); end
                default: begin ResultSrcE = 1'b1; RdE = 5'd12; Rs1D = 5'd12; sb.push_back(V_LW); end
            endcase
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL load_use_%0d got=%b exp=%b", i, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_muldiv();
        logic [12:0] seq[5] = '{V_MD1, V_MDB, V_MDB, V_MDEND, V_IDLE};
        for (int i = 0; i < 5; i++) begin
            clr_in();
            MulDivE = (i < 4);
            sb.push_back(seq[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL muldiv_cyc%0d got=%b exp=%b", i + 1, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_in_md();
        logic [12:0] seq[6] = '{V_MD1, V_MDB, V_MEMB, V_MEMB, V_MDEND, V_IDLE};
        for (int i = 0; i < 6; i++) begin
            clr_in();
            MulDivE    = (i < 5);
            DMemStallM = (i == 2) || (i == 3);
            sb.push_back(seq[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL mem_in_md_cyc%0d got=%b exp=%b", i + 1, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        logic [12:0] seq[4] = '{V_MEM, V_BR, V_BR, V_IDLE};
        for (int i = 0; i < 4; i++) begin
            clr_in();
            PCSrcE     = (i < 3);
            DMemStallM = (i == 0);
            if (i == 2) begin
                ResultSrcE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
            end
            sb.push_back(seq[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL branch_%0d got=%b exp=%b", i, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        clr_in();
        MulDivE = 1'b1;
        next_cycle();
        // now in MD_BUSY cycle 2
        #2 rst = 1'b1;
        #1;
        sb.push_back(V_RST);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL async_reset got=%b exp=%b", obs, exp_v);
        end
        next_cycle();
        rst = 1'b0;
        clr_in();
        sb.push_back(V_IDLE);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL after_reset_idle got=%b exp=%b", obs, exp_v);
        end
        next_cycle();
        // fresh MUL/DIV must take the full latency again
        for (int i = 0; i < 4; i++) begin
            clr_in();
            MulDivE = 1'b1;
            sb.push_back((i == 0) ? V_MD1 : ((i == 3) ? V_MDEND : V_MDB));
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL md_after_reset_cyc%0d got=%b exp=%b", i + 1, obs, exp_v);
            end
            next_cycle();
        end
        clr_in();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clr_in();
        test_reset();
        test_forward();
        test_load_use();
        test_muldiv();
        test_mem_in_md();
        test_branch();
        test_async_reset();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
